// File: rtl/rf_pkg.sv
// Shared register-file types and sizing constants for the integer register
// file and its write-back path.
package rf_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_ADDR_COUNT = 32;
  localparam int RF_DATA_WIDTH = 32;

  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;

  typedef struct packed {
    rf_addr_t addr;
    rf_data_t data;
  } rf_wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first asserted request at or
// after the pointer, with wrap-around; the pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] grant_idx;
  logic             found;

  // First pass looks at or above the pointer; the second pass covers the wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (PTR_W'(i) >= ptr)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, plus the
// pending-write scoreboard that decode uses for read-after-write stalls.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int ADDR_COUNT = RF_ADDR_COUNT,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       sb_set,
  input  logic [ADDR_WIDTH-1:0]      sb_set_addr,
  output logic [ADDR_COUNT-1:0]      busy,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic             handshake;
  logic [PTR_W-1:0] rr_ptr_unused;
  rf_wb_req_t       win;
  logic [ADDR_COUNT-1:0] busy_next;

  assign handshake = |(req_valid & req_ready);

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (handshake),
    .grant   (req_ready),
    .ptr     (rr_ptr_unused)
  );

  always_comb begin
    win = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        win.addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win.data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // x0 writes are accepted but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= handshake && (win.addr != '0);
      if (handshake) begin
        rf_waddr <= win.addr;
        rf_wdata <= win.data;
      end
    end
  end

  // Set is applied after clear so a newer producer keeps the bit busy.
  always_comb begin
    busy_next = busy;
    if (rf_wen) begin
      busy_next[rf_waddr] = 1'b0;
    end
    if (sb_set && (sb_set_addr != '0)) begin
      busy_next[sb_set_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the write-back rules.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int AC   = 32;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      ra [NREQ];
  logic [DW-1:0]      rd [NREQ];
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               sb_set;
  logic [AW-1:0]      sb_set_addr;
  logic [AC-1:0]      busy;
  logic               rf_wen;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;

  assign req_addr = {ra[2], ra[1], ra[0]};
  assign req_data = {rd[2], rd[1], rd[0]};

  rf_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .busy        (busy),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  int checks = 0;
  int errors = 0;

  int          m_ptr;
  logic        m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [AC-1:0] m_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_wen   = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_busy  = '0;
  endtask

  // Winner is the valid requester with the smallest circular distance from the pointer.
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    int best = -1;
    int bd   = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) begin
        int d = (i - p + NREQ) % NREQ;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic cycle(input string tag, output int g);
    logic [NREQ-1:0] er;
    #1;
    g  = pick(req_valid, m_ptr);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk({tag, ".ready"}, req_ready, er);
    @(posedge clk);
    if (m_wen) m_busy[m_waddr] = 1'b0;
    if (sb_set && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
    m_wen = (g >= 0) && (ra[g] != 0);
    if (g >= 0) begin
      m_waddr = ra[g];
      m_wdata = rd[g];
      m_ptr   = (g + 1) % NREQ;
    end
    #1;
    chk({tag, ".wen"}, rf_wen, m_wen);
    chk({tag, ".waddr"}, rf_waddr, m_waddr);
    chk({tag, ".wdata"}, rf_wdata, m_wdata);
    chk({tag, ".busy"}, busy, m_busy);
  endtask

  task automatic idle();
    req_valid   = '0;
    sb_set      = 1'b0;
    sb_set_addr = '0;
  endtask

  initial begin
    int g;
    int w [NREQ];
    logic [AC-1:0] b0;

    idle();
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = '0;
      rd[i] = '0;
      w[i]  = 0;
    end
    model_reset();

    // Reset state
    #12;
    chk("reset.wen", rf_wen, 1'b0);
    chk("reset.waddr", rf_waddr, 5'd0);
    chk("reset.wdata", rf_wdata, 32'd0);
    chk("reset.busy", busy, 32'd0);
    req_valid = 3'b111;
    #1;
    chk("reset.ready", req_ready, 3'b001);
    rst_n = 1'b1;

    // All three requesters valid: strict rotation 0,1,2,0,1,2
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = AW'(i + 1);
      rd[i] = $urandom;
    end
    for (int k = 0; k < 6; k++) begin
      cycle("rr", g);
      chk("rr.order", g, k % 3);
      chk("rr.wen_lag", rf_wen, 1'b1);
    end
    idle();
    cycle("rr.drain", g);
    chk("rr.drain_wen", rf_wen, 1'b0);

    // Single requester 1 writes x5
    req_valid = 3'b010;
    ra[1] = 5'd5;
    rd[1] = 32'hDEADBEEF;
    #1;
    chk("single.ready", req_ready, 3'b010);
    cycle("single", g);
    chk("single.wen", rf_wen, 1'b1);
    chk("single.waddr", rf_waddr, 5'd5);
    chk("single.wdata", rf_wdata, 32'hDEADBEEF);
    idle();

    // Write to x0 is accepted but suppressed
    b0 = busy;
    req_valid = 3'b001;
    ra[0] = 5'd0;
    rd[0] = 32'h1234;
    cycle("x0", g);
    chk("x0.granted", g, 0);
    chk("x0.wen", rf_wen, 1'b0);
    chk("x0.busy", busy, b0);
    idle();

    // Scoreboard lifetime of x7
    sb_set = 1'b1;
    sb_set_addr = 5'd7;
    cycle("sb7.set", g);
    chk("sb7.busy_set", busy[7], 1'b1);
    idle();
    cycle("sb7.wait", g);
    chk("sb7.busy_hold", busy[7], 1'b1);
    req_valid = 3'b001;
    ra[0] = 5'd7;
    rd[0] = $urandom;
    cycle("sb7.write", g);
    chk("sb7.busy_during_wen", busy[7], 1'b1);
    idle();
    cycle("sb7.commit", g);
    chk("sb7.busy_clear", busy[7], 1'b0);

    // Clear and set of x9 on the same edge: set wins
    sb_set = 1'b1;
    sb_set_addr = 5'd9;
    cycle("sb9.set", g);
    idle();
    req_valid = 3'b100;
    ra[2] = 5'd9;
    rd[2] = $urandom;
    cycle("sb9.write", g);
    idle();
    sb_set = 1'b1;
    sb_set_addr = 5'd9;
    cycle("sb9.collide", g);
    chk("sb9.busy_kept", busy[9], 1'b1);
    idle();
    req_valid = 3'b001;
    ra[0] = 5'd9;
    cycle("sb9.write2", g);
    idle();
    cycle("sb9.clear", g);
    chk("sb9.busy_clear", busy[9], 1'b0);

    // Reset while a write is in flight and x7 is busy
    sb_set = 1'b1;
    sb_set_addr = 5'd7;
    req_valid = 3'b010;
    ra[1] = 5'd3;
    rd[1] = $urandom;
    cycle("rst.prep", g);
    chk("rst.prep_busy", busy, 32'h80);
    chk("rst.prep_wen", rf_wen, 1'b1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.wen", rf_wen, 1'b0);
    chk("rst.busy", busy, 32'd0);
    chk("rst.waddr", rf_waddr, 5'd0);
    chk("rst.wdata", rf_wdata, 32'd0);
    req_valid = 3'b110;
    #1;
    chk("rst.ready_110", req_ready, 3'b010);
    req_valid = 3'b111;
    #1;
    chk("rst.ready_111", req_ready, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 3'b110;
    cycle("rst.first", g);
    chk("rst.first_grant", g, 1);
    idle();

    // Randomized traffic; requests held stable until granted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          ra[i] = AW'($urandom_range(0, AC - 1));
          rd[i] = $urandom;
        end
      end
      sb_set = ($urandom_range(0, 3) == 0);
      sb_set_addr = AW'($urandom_range(0, AC - 1));
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i]) w[i]++;
      end
      cycle("rand", g);
      if (g >= 0) begin
        chk("rand.starve", (w[g] <= NREQ), 1'b1);
        req_valid[g] = 1'b0;
        w[g] = 0;
      end
    end
    idle();
    cycle("final", g);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard for the integer register file. It shares the register file's single write port between NREQ producers (ALU, load unit, JAL/link path) using round-robin valid/ready handshakes. It registers the winning write onto the register file's wen/waddr/wdata inputs. It also tracks which architectural registers have an outstanding producer, so decode can stall on read-after-write hazards.

## Interface
- NREQ, 3, number of write-back requesters; index 0 has the highest priority after reset.
- ADDR_WIDTH, 5, register index width.
- ADDR_COUNT, 32, number of architectural registers.
- DATA_WIDTH, 32, register data width.
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ*ADDR_WIDTH  destination index, requester i in slice i.
- req_data  input  NREQ*DATA_WIDTH  write data, requester i in slice i.
- req_ready  output  NREQ  one-hot or zero; grant to requester i this cycle.
- sb_set  input  1  issue of an instruction with a destination register.
- sb_set_addr  input  ADDR_WIDTH  destination of the issuing instruction.
- busy  output  ADDR_COUNT  bit a set while register a has an uncommitted producer.
- rf_wen  output  1  register-file write enable (registered).
- rf_waddr  output  ADDR_WIDTH  register-file write index (registered).
- rf_wdata  output  DATA_WIDTH  register-file write data (registered).

## Operation
- Arbitration is round-robin over the asserted req_valid bits, starting at pointer ptr.
  - The first valid index at or after ptr, with wrap-around, wins.
  - req_ready is combinational from req_valid and ptr.
  - At most one bit of req_ready is high. All bits are low when no request is valid.
- A handshake occurs when req_valid[i] and req_ready[i] are both high at a posedge.
  - ptr becomes (i+1) mod NREQ.
  - Without a handshake, ptr holds.
- The output stage is a single register loaded every cycle:
  - rf_wen <= handshake && addr != 0.
  - rf_waddr <= the winner's address, otherwise it holds.
  - rf_wdata <= the winner's data, otherwise it holds.
- Writes to x0 are accepted (ready is asserted) but never produce rf_wen.
- Scoreboard:
  - sb_set with sb_set_addr != 0 sets busy[sb_set_addr].
  - busy[rf_waddr] clears at the posedge where rf_wen is high, which is the same edge the register file captures the data.
  - busy[0] is constantly 0.
- Set and clear of the same index on the same edge: set wins, because a newer producer is in flight.
- A request to a non-busy register is legal. It writes normally, and the clear of an already-clear bit is a no-op.
- Requesters must hold req_valid, req_addr and req_data stable until the handshake. The block never drops an asserted request.

## Timing
- Reset (async assert, sync-safe deassert) sets the following; a reset mid-operation discards any in-flight output write.
  - ptr = 0, rf_wen = 0, rf_waddr = 0, rf_wdata = 0, busy = all zero.
  - req_ready is a function of req_valid only, with ptr = 0.
- Latency:
  - Handshake at edge E: rf_wen is high during the cycle after E, and the register file writes at edge E+1.
  - busy drops at edge E+1, so a reader sampling busy == 0 sees the new value.
- Throughput: one write per cycle sustained. Back-to-back writes to the same index commit in grant order.
- Starvation bound: a continuously valid requester is granted within NREQ cycles.

## Structure
- Shared package rf_pkg holds:
  - the RF_ADDR_WIDTH, RF_ADDR_COUNT and RF_DATA_WIDTH constants;
  - typedef rf_addr_t and typedef rf_data_t;
  - typedef struct rf_wb_req_t {addr, data}.
- Sub-module rr_arbiter, parameterised by N.
  - Inputs: clk, rst_n, req, advance.
  - Outputs: one-hot grant and the internal pointer.
  - rf_wb_arbiter instantiates it with advance = |(req_valid & req_ready).

## Test plan
- After reset, req_valid=3'b111 held for 6 cycles -> grants in order 0,1,2,0,1,2. rf_wen is high in 6 consecutive cycles, each lagging its grant by one.
- Single requester 1 writes addr 5, data 0xDEADBEEF -> req_ready=3'b010 that cycle. Next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- Requester 0 writes addr 0, data 0x1234 -> ready is granted, rf_wen stays 0, and busy is unchanged.
- sb_set addr 7, then a write to addr 7 two cycles later -> busy[7]=1 from the edge after sb_set until the edge where rf_wen is high, then 0.
- Clear of busy[9] coinciding with a new sb_set addr 9 -> busy[9] remains 1.
- rst_n pulsed low while rf_wen=1 and busy=0x80 -> immediately rf_wen=0, busy=0, ptr=0. The first grant after reset goes to the lowest-indexed valid requester.
